// File: rtl/sync_mod_counter_if.sv
// Control and status bundle of one modulo counter stage.
// The master drives enable/direction/load; the counter (slave) returns count and events.
interface sync_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrapped;

    modport master (
        output en, up, load, load_val,
        input  q, tc, wrapped
    );

    modport slave (
        input  en, up, load, load_val,
        output q, tc, wrapped
    );
endinterface

// File: rtl/sync_mod_counter.sv
// Synchronous up/down modulo counter with clamped parallel load, wrap/saturate
// option, registered limit-event pulse and combinational terminal count for cascading.
module sync_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter bit SATURATE  = 1'b0,
    parameter int RESET_VAL = 0
) (
    input  logic               clock,
    input  logic               clear,
    sync_mod_counter_if.slave  cnt
);
    // Compare in WIDTH+1 bits so MODULUS == 2**WIDTH stays representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic             at_max;
    logic             at_zero;
    logic             at_limit;
    logic [WIDTH:0]   inc_ext;

    always_comb begin
        at_max   = ({1'b0, count_q} == MAX_EXT);
        at_zero  = (count_q == '0);
        at_limit = cnt.up ? at_max : at_zero;
        inc_ext  = {1'b0, count_q} + (WIDTH + 1)'(1);

        count_d   = count_q;
        wrapped_d = 1'b0;

        if (cnt.load) begin
            if ({1'b0, cnt.load_val} < MOD_EXT) begin
                count_d = cnt.load_val;
            end else begin
                count_d = MAX_VAL;
            end
        end else if (cnt.en) begin
            wrapped_d = at_limit;
            if (cnt.up) begin
                if (at_max) begin
                    count_d = SATURATE ? count_q : '0;
                end else begin
                    count_d = inc_ext[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    count_d = SATURATE ? count_q : MAX_VAL;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            count_q   <= RST_VAL;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    // tc feeds the next stage's en, so it must not wait for a clock edge.
    assign cnt.tc      = cnt.en & ~cnt.load & ~clear & at_limit;
    assign cnt.q       = count_q;
    assign cnt.wrapped = wrapped_q;

endmodule

// File: tb/tb_sync_mod_counter.sv
// Randomized and directed bench for sync_mod_counter: three standalone stages
// with different parameters plus a two-stage decimal cascade, against an arithmetic model.
module tb_sync_mod_counter;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       clear_s, load_s, en_s, up_s;
    logic [3:0] lv_s;
    logic       cas_en, cas_up;

    int n_vec = 0;
    int n_err = 0;

    sync_mod_counter_if #(.WIDTH(4)) if_a (), if_s (), if_f (), if_c0 (), if_c1 ();

    assign if_a.en = en_s;  assign if_a.up = up_s;  assign if_a.load = load_s;  assign if_a.load_val = lv_s;
    assign if_s.en = en_s;  assign if_s.up = up_s;  assign if_s.load = load_s;  assign if_s.load_val = lv_s;
    assign if_f.en = en_s;  assign if_f.up = up_s;  assign if_f.load = load_s;  assign if_f.load_val = lv_s;

    assign if_c0.en = cas_en;     assign if_c0.up = cas_up;  assign if_c0.load = 1'b0;  assign if_c0.load_val = 4'd0;
    assign if_c1.en = if_c0.tc;   assign if_c1.up = cas_up;  assign if_c1.load = 1'b0;  assign if_c1.load_val = 4'd0;

    sync_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VAL(3))
        u_wrap10 (.clock(clock), .clear(clear_s), .cnt(if_a));
    sync_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RESET_VAL(0))
        u_sat10  (.clock(clock), .clear(clear_s), .cnt(if_s));
    sync_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .RESET_VAL(0))
        u_full16 (.clock(clock), .clear(clear_s), .cnt(if_f));
    sync_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VAL(0))
        u_dec0   (.clock(clock), .clear(clear_s), .cnt(if_c0));
    sync_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VAL(0))
        u_dec1   (.clock(clock), .clear(clear_s), .cnt(if_c1));

    // Reference model: standalone counters as plain integers, cascade as one 0..99 value.
    int MODS [3] = '{10, 10, 16};
    bit SATS [3] = '{1'b0, 1'b1, 1'b0};
    int RVS  [3] = '{3, 0, 0};
    int mq   [3] = '{0, 0, 0};
    bit mw   [3] = '{1'b0, 1'b0, 1'b0};
    int cv = 0;
    bit cw = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dut_q(input int i);
        case (i)
            0:       return int'(if_a.q);
            1:       return int'(if_s.q);
            default: return int'(if_f.q);
        endcase
    endfunction

    function automatic int dut_tc(input int i);
        case (i)
            0:       return int'(if_a.tc);
            1:       return int'(if_s.tc);
            default: return int'(if_f.tc);
        endcase
    endfunction

    function automatic int dut_w(input int i);
        case (i)
            0:       return int'(if_a.wrapped);
            1:       return int'(if_s.wrapped);
            default: return int'(if_f.wrapped);
        endcase
    endfunction

    task automatic step();
        int  m;
        bit  lim;
        #1;
        for (int i = 0; i < 3; i++) begin
            m   = MODS[i];
            lim = up_s ? (mq[i] == m - 1) : (mq[i] == 0);
            check($sformatf("tc[%0d]", i), dut_tc(i), int'(en_s && !load_s && !clear_s && lim));
        end
        check("tc_dec0", int'(if_c0.tc),
              int'(cas_en && !clear_s && (cas_up ? (cv % 10 == 9) : (cv % 10 == 0))));
        check("tc_dec1", int'(if_c1.tc),
              int'(cas_en && !clear_s && (cas_up ? (cv == 99) : (cv == 0))));

        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            m = MODS[i];
            if (clear_s) begin
                mq[i] = RVS[i];
                mw[i] = 1'b0;
            end else if (load_s) begin
                mq[i] = (int'(lv_s) < m) ? int'(lv_s) : m - 1;
                mw[i] = 1'b0;
            end else if (en_s) begin
                lim   = up_s ? (mq[i] == m - 1) : (mq[i] == 0);
                mw[i] = lim;
                if (!(lim && SATS[i]))
                    mq[i] = up_s ? (mq[i] + 1) % m : (mq[i] + m - 1) % m;
            end else begin
                mw[i] = 1'b0;
            end
        end
        if (clear_s) begin
            cv = 0;
            cw = 1'b0;
        end else if (cas_en) begin
            cw = cas_up ? (cv == 99) : (cv == 0);
            cv = cas_up ? (cv + 1) % 100 : (cv + 99) % 100;
        end else begin
            cw = 1'b0;
        end

        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("q[%0d]", i), dut_q(i), mq[i]);
            check($sformatf("wrapped[%0d]", i), dut_w(i), int'(mw[i]));
        end
        check("dec_value", int'(if_c1.q) * 10 + int'(if_c0.q), cv);
        check("dec_wrapped", int'(if_c1.wrapped), int'(cw));
    endtask

    task automatic drive(input bit c, input bit l, input int v, input bit e, input bit u);
        clear_s = c;
        load_s  = l;
        lv_s    = 4'(v);
        en_s    = e;
        up_s    = u;
    endtask

    initial begin
        int wrap_cnt;
        cas_en = 1'b1;
        cas_up = 1'b1;

        // Clear overrides load and enable.
        drive(1, 1, 5, 1, 1);
        step();
        check("t1_clear_q", int'(if_a.q), 3);
        check("t1_clear_wrapped", int'(if_a.wrapped), 0);

        // Up-count wrap at 9 -> 0.
        cas_en = 1'b0;
        drive(0, 1, 0, 0, 1);
        step();
        drive(0, 0, 0, 1, 1);
        repeat (12) step();
        check("t2_final_q", int'(if_a.q), 2);

        // Down-count saturating at zero.
        drive(0, 1, 2, 0, 0);
        step();
        drive(0, 0, 0, 1, 0);
        repeat (4) step();
        check("t3_sat_q", int'(if_s.q), 0);
        check("t3_sat_wrapped", int'(if_s.wrapped), 1);

        // Load clamp, then clear beats load.
        drive(0, 1, 13, 1, 1);
        step();
        check("t4_clamp_q", int'(if_a.q), 9);
        check("t4_full_load_q", int'(if_f.q), 13);
        drive(1, 1, 7, 1, 1);
        step();
        check("t4_clear_q", int'(if_a.q), 3);

        // Two-digit decimal cascade: 100 edges return to 00 with one carry out.
        drive(0, 0, 0, 0, 1);
        cas_en   = 1'b1;
        cas_up   = 1'b1;
        wrap_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (if_c1.wrapped) wrap_cnt++;
        end
        check("t5_dec_value", int'(if_c1.q) * 10 + int'(if_c0.q), 0);
        check("t5_carry_count", wrap_cnt, 1);

        // Full-range modulus wraps in both directions.
        cas_en = 1'b0;
        drive(0, 1, 0, 0, 0);
        step();
        drive(0, 0, 0, 1, 0);
        step();
        check("t6_down_q", int'(if_f.q), 15);
        check("t6_down_wrapped", int'(if_f.wrapped), 1);
        drive(0, 0, 0, 1, 1);
        step();
        check("t6_up_q", int'(if_f.q), 0);

        // Random mix with sticky direction so limits are reached regularly.
        for (int k = 0; k < 400; k++) begin
            clear_s = ($urandom_range(0, 31) == 0);
            load_s  = ($urandom_range(0, 9) == 0);
            lv_s    = 4'($urandom_range(0, 15));
            en_s    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) up_s = ~up_s;
            cas_en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) cas_up = ~cas_up;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
